// File: rtl/npu_dma_sched_if.sv
// Command/status bus between the DMA scheduler and npu_dma.
// The master side issues transfers and the slave side reports progress.
interface npu_dma_sched_if;
  logic [31:0] rd_addr;
  logic [31:0] wr_addr;
  logic [31:0] rd_len;
  logic [31:0] wr_len;
  logic        rd_start_pulse;
  logic        wr_start_pulse;
  logic        rd_busy;
  logic        rd_done;
  logic        wr_busy;
  logic        wr_done;

  modport master (
    output rd_addr, wr_addr, rd_len, wr_len, rd_start_pulse, wr_start_pulse,
    input  rd_busy, rd_done, wr_busy, wr_done
  );

  modport slave (
    input  rd_addr, wr_addr, rd_len, wr_len, rd_start_pulse, wr_start_pulse,
    output rd_busy, rd_done, wr_busy, wr_done
  );
endinterface

// File: rtl/npu_dma_sched.sv
// Descriptor queue plus issue FSM for npu_dma: pops one descriptor at a time,
// fires paired read/write starts, waits for both dones, and guards with a watchdog.
module npu_dma_sched #(
  parameter int unsigned DESC_DEPTH = 4,
  parameter int unsigned DESC_AW    = 2,
  parameter int unsigned TO_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                desc_valid,
  output logic                desc_ready,
  input  logic [31:0]         desc_rd_addr,
  input  logic [31:0]         desc_wr_addr,
  input  logic [31:0]         desc_len,
  input  logic [TO_WIDTH-1:0] to_limit,
  input  logic                irq_en,
  input  logic                irq_clear,
  input  logic                err_clear,
  npu_dma_sched_if.master     dma,
  output logic                busy,
  output logic                err,
  output logic                irq,
  output logic [15:0]         done_count,
  output logic [DESC_AW:0]    queue_level
);

  localparam logic [DESC_AW:0] LevelFull = (DESC_AW + 1)'(DESC_DEPTH);

  typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWait, StErr} state_e;

  state_e state_q, state_d;

  logic [31:0] mem_rd_addr [DESC_DEPTH];
  logic [31:0] mem_wr_addr [DESC_DEPTH];
  logic [31:0] mem_len     [DESC_DEPTH];

  logic [DESC_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DESC_AW:0]    level_q;
  logic [31:0]         rd_addr_q, wr_addr_q, len_q;
  logic [TO_WIDTH-1:0] wd_q;
  logic                err_q, irq_q;
  logic [15:0]         done_cnt_q;

  logic push, pop, flush;
  logic wait_complete, wait_timeout, wd_hit;
  logic start_pulse;

  // Busy flags are informational only; nothing in the schedule depends on them.
  logic unused_dma_busy;
  assign unused_dma_busy = dma.rd_busy ^ dma.wr_busy;

  assign desc_ready = (level_q != LevelFull);
  assign push       = desc_valid && desc_ready;
  assign pop        = (state_q == StLoad);
  assign flush      = (state_q == StErr) && err_clear;
  assign wd_hit     = (to_limit != '0) && (wd_q == to_limit - 1'b1);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_addr[wr_ptr_q] <= desc_rd_addr;
      mem_wr_addr[wr_ptr_q] <= desc_wr_addr;
      mem_len[wr_ptr_q]     <= desc_len;
    end
  end

  // A flush wins over any push in the same cycle, so that push is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (!push && pop) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_complete = 1'b0;
    wait_timeout  = 1'b0;
    unique case (state_q)
      StIdle:  if (enable && (level_q != '0)) state_d = StLoad;
      StLoad:  state_d = StIssue;
      StIssue: state_d = StWait;
      StWait: begin
        if (dma.rd_done && dma.wr_done) begin
          wait_complete = 1'b1;
          state_d       = StIdle;
        end else if (wd_hit) begin
          wait_timeout = 1'b1;
          state_d      = StErr;
        end
      end
      StErr:   if (err_clear) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    start_pulse = (state_q == StIssue);
    busy        = (state_q == StLoad) || (state_q == StIssue) || (state_q == StWait);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      len_q      <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      if (pop) begin
        rd_addr_q <= mem_rd_addr[rd_ptr_q];
        wr_addr_q <= mem_wr_addr[rd_ptr_q];
        len_q     <= mem_len[rd_ptr_q];
      end
      if (state_q == StIssue) begin
        wd_q <= '0;
      end else if ((state_q == StWait) && !wait_complete && !wait_timeout) begin
        wd_q <= wd_q + 1'b1;
      end
      if (wait_timeout) begin
        err_q <= 1'b1;
      end else if (flush) begin
        err_q <= 1'b0;
      end
      // Setting the interrupt takes priority over a coincident clear.
      if (irq_en && (wait_complete || wait_timeout)) begin
        irq_q <= 1'b1;
      end else if (irq_clear) begin
        irq_q <= 1'b0;
      end
      if (wait_complete) done_cnt_q <= done_cnt_q + 1'b1;
    end
  end

  assign dma.rd_addr        = rd_addr_q;
  assign dma.wr_addr        = wr_addr_q;
  assign dma.rd_len         = len_q;
  assign dma.wr_len         = len_q;
  assign dma.rd_start_pulse = start_pulse;
  assign dma.wr_start_pulse = start_pulse;
  assign err                = err_q;
  assign irq                = irq_q;
  assign done_count         = done_cnt_q;
  assign queue_level        = level_q;

endmodule

// File: tb/tb_npu_dma_sched.sv
// Directed bench for npu_dma_sched; the bench plays the npu_dma side by hand.
module tb_npu_dma_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] desc_rd_addr, desc_wr_addr, desc_len;
  logic [15:0] to_limit;
  logic        irq_en, irq_clear, err_clear;
  logic        busy, err, irq;
  logic [15:0] done_count;
  logic [2:0]  queue_level;

  int compared = 0;
  int mismatched = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;

  npu_dma_sched_if dma ();

  npu_dma_sched #(
    .DESC_DEPTH (4),
    .DESC_AW    (2),
    .TO_WIDTH   (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .desc_valid   (desc_valid),
    .desc_ready   (desc_ready),
    .desc_rd_addr (desc_rd_addr),
    .desc_wr_addr (desc_wr_addr),
    .desc_len     (desc_len),
    .to_limit     (to_limit),
    .irq_en       (irq_en),
    .irq_clear    (irq_clear),
    .err_clear    (err_clear),
    .dma          (dma.master),
    .busy         (busy),
    .err          (err),
    .irq          (irq),
    .done_count   (done_count),
    .queue_level  (queue_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (dma.rd_start_pulse) rd_pulses++;
    if (dma.wr_start_pulse) wr_pulses++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0; desc_valid = 1'b0;
    desc_rd_addr = '0; desc_wr_addr = '0; desc_len = '0;
    to_limit = '0; irq_en = 1'b0; irq_clear = 1'b0; err_clear = 1'b0;
    dma.rd_busy = 1'b0; dma.wr_busy = 1'b0; dma.rd_done = 1'b0; dma.wr_done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    rd_pulses = 0;
    wr_pulses = 0;
  endtask

  task automatic push(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] len);
    desc_valid = 1'b1;
    desc_rd_addr = ra; desc_wr_addr = wa; desc_len = len;
    tick();
    desc_valid = 1'b0;
  endtask

  // Waits for the start pulse, checks the issued descriptor, then drops the
  // done flags just as npu_dma does on the edge that samples the start.
  task automatic wait_pulse(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] len);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (dma.rd_start_pulse) seen = 1'b1;
    end
    check("start_seen", 32'(seen), 32'd1);
    check("wr_start_pair", 32'(dma.wr_start_pulse), 32'(seen));
    check("rd_addr", dma.rd_addr, ra);
    check("wr_addr", dma.wr_addr, wa);
    check("rd_len", dma.rd_len, len);
    check("wr_len", dma.wr_len, len);
    dma.rd_done = 1'b0;
    dma.wr_done = 1'b0;
  endtask

  task automatic finish_xfer(input int lat);
    repeat (lat) tick();
    dma.rd_done = 1'b1;
    dma.wr_done = 1'b1;
    tick();
  endtask

  initial begin
    // Reset values
    rst_n = 1'b0;
    do_reset();
    rst_n = 1'b0;
    tick();
    check("rst_desc_ready", 32'(desc_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_done_count", 32'(done_count), 32'd0);
    check("rst_level", 32'(queue_level), 32'd0);
    check("rst_rd_addr", dma.rd_addr, 32'd0);
    check("rst_start", 32'(dma.rd_start_pulse | dma.wr_start_pulse), 32'd0);
    rst_n = 1'b1;

    // Single descriptor: pulse lands three cycles after the push cycle
    enable = 1'b1; irq_en = 1'b1;
    push(32'h1000, 32'h2000, 32'd20);
    check("t1_level", 32'(queue_level), 32'd1);
    check("t1_c1_nopulse", 32'(dma.rd_start_pulse), 32'd0);
    tick();
    check("t1_c2_busy", 32'(busy), 32'd1);
    check("t1_c2_nopulse", 32'(dma.rd_start_pulse), 32'd0);
    tick();
    check("t1_c3_rd_pulse", 32'(dma.rd_start_pulse), 32'd1);
    check("t1_c3_wr_pulse", 32'(dma.wr_start_pulse), 32'd1);
    check("t1_rd_addr", dma.rd_addr, 32'h1000);
    check("t1_wr_addr", dma.wr_addr, 32'h2000);
    check("t1_rd_len", dma.rd_len, 32'd20);
    check("t1_wr_len", dma.wr_len, 32'd20);
    finish_xfer(50);
    check("t1_done_count", 32'(done_count), 32'd1);
    check("t1_irq", 32'(irq), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_rd_pulses", 32'(rd_pulses), 32'd1);
    check("t1_wr_pulses", 32'(wr_pulses), 32'd1);

    // Five descriptors into a four-deep queue while disabled
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(32'h10000 + 32'(i) * 32'h100, 32'h20000 + 32'(i) * 32'h100, 32'(i + 1));
    end
    desc_valid = 1'b1;
    desc_rd_addr = 32'h10400; desc_wr_addr = 32'h20400; desc_len = 32'd5;
    check("t2_full_ready", 32'(desc_ready), 32'd0);
    check("t2_full_level", 32'(queue_level), 32'd4);
    tick();
    check("t2_stall_level", 32'(queue_level), 32'd4);
    enable = 1'b1;
    wait_pulse(32'h10000, 32'h20000, 32'd1);
    tick();
    desc_valid = 1'b0;
    check("t2_fifth_pushed", 32'(queue_level), 32'd4);
    finish_xfer(4);
    for (int i = 1; i < 5; i++) begin
      wait_pulse(32'h10000 + 32'(i) * 32'h100, 32'h20000 + 32'(i) * 32'h100, 32'(i + 1));
      finish_xfer(5);
    end
    check("t2_done_count", 32'(done_count), 32'd5);
    check("t2_pulses", 32'(rd_pulses), 32'd5);
    check("t2_level_empty", 32'(queue_level), 32'd0);

    // rd_done ten cycles ahead of wr_done
    do_reset();
    enable = 1'b1;
    push(32'h3000, 32'h4000, 32'd0);
    wait_pulse(32'h3000, 32'h4000, 32'd0);
    tick();
    dma.rd_done = 1'b1;
    repeat (10) tick();
    check("t3_no_early_done", 32'(done_count), 32'd0);
    check("t3_still_busy", 32'(busy), 32'd1);
    dma.wr_done = 1'b1;
    tick();
    check("t3_done_count", 32'(done_count), 32'd1);
    repeat (5) tick();
    check("t3_pulses", 32'(rd_pulses), 32'd1);

    // Watchdog: ERR exactly 100 WAIT cycles in, then flush on err_clear
    do_reset();
    enable = 1'b1; irq_en = 1'b1; to_limit = 16'd100;
    push(32'h5000, 32'h6000, 32'd8);
    wait_pulse(32'h5000, 32'h6000, 32'd8);
    tick();
    repeat (99) tick();
    check("t4_err_before", 32'(err), 32'd0);
    tick();
    check("t4_err", 32'(err), 32'd1);
    check("t4_irq", 32'(irq), 32'd1);
    check("t4_not_busy", 32'(busy), 32'd0);
    push(32'h7000, 32'h8000, 32'd1);
    push(32'h7100, 32'h8100, 32'd2);
    check("t4_err_level", 32'(queue_level), 32'd2);
    err_clear = 1'b1;
    desc_valid = 1'b1;
    tick();
    err_clear = 1'b0;
    desc_valid = 1'b0;
    check("t4_err_cleared", 32'(err), 32'd0);
    check("t4_flushed", 32'(queue_level), 32'd0);
    repeat (10) tick();
    check("t4_no_more_pulses", 32'(rd_pulses), 32'd1);
    check("t4_idle", 32'(busy), 32'd0);

    // irq set beats a coincident clear; a lone clear then drops it
    do_reset();
    enable = 1'b1; irq_en = 1'b1;
    push(32'h9000, 32'hA000, 32'd3);
    wait_pulse(32'h9000, 32'hA000, 32'd3);
    repeat (3) tick();
    dma.rd_done = 1'b1; dma.wr_done = 1'b1; irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    check("t5_set_wins", 32'(irq), 32'd1);
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    check("t5_cleared", 32'(irq), 32'd0);
    irq_en = 1'b0;
    push(32'h9100, 32'hA100, 32'd4);
    wait_pulse(32'h9100, 32'hA100, 32'd4);
    finish_xfer(2);
    check("t5_irq_masked", 32'(irq), 32'd0);
    check("t5_done_count", 32'(done_count), 32'd2);

    // Reset during WAIT with three descriptors still queued
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(32'hB000 + 32'(i), 32'hC000 + 32'(i), 32'd7);
    end
    enable = 1'b1;
    wait_pulse(32'hB000, 32'hC000, 32'd7);
    repeat (3) tick();
    check("t6_wait_busy", 32'(busy), 32'd1);
    check("t6_wait_level", 32'(queue_level), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_level", 32'(queue_level), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done_count", 32'(done_count), 32'd0);
    check("t6_rd_addr", dma.rd_addr, 32'd0);
    check("t6_rd_len", dma.rd_len, 32'd0);
    check("t6_ready", 32'(desc_ready), 32'd1);
    repeat (5) tick();
    check("t6_no_pulses", 32'(rd_pulses), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
